exe_muldiv: RTL and testbench

Iterative 32-bit multiply/divide unit for the execute stage. It consumes the decoded operands and function code that the ID/EX pipeline register presents to EXE, and computes MULT/MULTU/DIV/DIVU over 32 iterations into architectural HI/LO registers. It also services MTHI/MTLO. It holds the front end through `stall_req` while an operation is in flight.

---
 rtl/exe_muldiv_pkg.sv | 42 ++++
 rtl/exe_muldiv_if.sv | 30 +++
 rtl/exe_muldiv.sv | 231 +++++++++++++++++++++++
 tb/tb_exe_muldiv.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/exe_muldiv_pkg.sv
// Shared CPU definitions used by the execute-stage multiply/divide unit.
// Contents:
//   FUNCT_*      MIPS funct codes that touch the HI/LO registers
//   md_state_t   control state of the iterative mul/div engine
//   is_muldiv()  true for the four funct codes that start a 32-iteration op
//   is_signed_md() true for the signed mul/div funct codes
package cpu_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  function automatic logic is_muldiv(input logic [5:0] funct);
    logic r;
    case (funct)
      FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: r = 1'b1;
      default:                                        r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_signed_md(input logic [5:0] funct);
    logic r;
    case (funct)
      FUNCT_MULT, FUNCT_DIV: r = 1'b1;
      default:               r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/exe_muldiv_if.sv
// Handshake/data bundle between the EXE stage and the mul/div unit.
// master : EXE side, drives start/inst_func/val1_in/val2_in/flush and reads
//          busy/stall_req/done/hi/lo.
// slave  : the mul/div unit.
interface exe_muldiv_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic [5:0]       inst_func;
  logic [WIDTH-1:0] val1_in;
  logic [WIDTH-1:0] val2_in;
  logic             flush;
  logic             busy;
  logic             stall_req;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, inst_func, val1_in, val2_in, flush,
    input  busy, stall_req, done, hi, lo
  );

  modport slave (
    input  start, inst_func, val1_in, val2_in, flush,
    output busy, stall_req, done, hi, lo
  );

endinterface

// File: rtl/exe_muldiv.sv
// Iterative multiply/divide unit for the execute stage.
// Computes MULT/MULTU/DIV/DIVU over ITERS iterations into HI/LO and services
// MTHI/MTLO in a single edge.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  exe_muldiv_if.slave:
//        in : start, inst_func, val1_in, val2_in, flush
//        out: busy (registered), stall_req (= busy), done (1-cycle pulse),
//             hi, lo (architectural HI/LO)
// Operands are reduced to magnitudes at issue; the sign is re-applied in FIX.
// A single WIDTH+1 adder serves both the shift-add multiply and the restoring
// divide.
module exe_muldiv
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = 32   // must equal WIDTH
) (
  input logic        clk,
  input logic        rst,
  exe_muldiv_if.slave bus
);

  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITERS - 1);

  md_state_t        state;
  md_state_t        state_next;
  logic [CNT_W-1:0] cnt;
  logic             op_div;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;
  logic [WIDTH-1:0] operand;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0] orig_val1;  // dividend as issued, for the divide-by-zero result
  logic [WIDTH-1:0] acc_hi;     // product high half / partial remainder
  logic [WIDTH-1:0] acc_lo;     // multiplier bits then product low half / quotient
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             done;
  logic             busy;

  // control strobes
  logic accept;
  logic iterate;
  logic finish;
  logic mt_hi;
  logic mt_lo;

  // issue-time operand conditioning
  logic             sign1;
  logic             sign2;
  logic [WIDTH-1:0] abs1;
  logic [WIDTH-1:0] abs2;

  // shared adder
  logic [WIDTH:0]   add_a;
  logic [WIDTH:0]   add_b;
  logic             add_cin;
  logic [WIDTH:0]   add_sum;
  logic             add_cout;

  // FIX-stage results
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and control strobes; flush overrides everything.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    iterate    = 1'b0;
    finish     = 1'b0;
    mt_hi      = 1'b0;
    mt_lo      = 1'b0;
    if (bus.flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && is_muldiv(bus.inst_func)) begin
            state_next = RUN;
            accept     = 1'b1;
          end else begin
            state_next = IDLE;
            mt_hi      = bus.start && (bus.inst_func == FUNCT_MTHI);
            mt_lo      = bus.start && (bus.inst_func == FUNCT_MTLO);
          end
        end
        RUN: begin
          iterate = 1'b1;
          if (cnt == CNT_LAST) begin
            state_next = FIX;
          end else begin
            state_next = RUN;
          end
        end
        FIX: begin
          finish     = 1'b1;
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Magnitudes of the issuing operands (only signed ops take absolute values).
  always_comb begin
    sign1 = is_signed_md(bus.inst_func) && bus.val1_in[WIDTH-1];
    sign2 = is_signed_md(bus.inst_func) && bus.val2_in[WIDTH-1];
    abs1  = sign1 ? (-bus.val1_in) : bus.val1_in;
    abs2  = sign2 ? (-bus.val2_in) : bus.val2_in;
  end

  // Shared adder: add multiplicand for multiply, subtract divisor for divide.
  // For divide the carry out is the "no borrow" flag, i.e. remainder >= divisor.
  always_comb begin
    if (op_div) begin
      add_a   = {acc_hi, acc_lo[WIDTH-1]};
      add_b   = ~{1'b0, operand};
      add_cin = 1'b1;
    end else begin
      add_a   = {1'b0, acc_hi};
      add_b   = acc_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}};
      add_cin = 1'b0;
    end
    {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, add_cin};
  end

  // Sign correction applied in FIX.
  always_comb begin
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_q ? (-prod) : prod;
    quo_fix  = neg_q ? (-acc_lo) : acc_lo;
    rem_fix  = neg_r ? (-acc_hi) : acc_hi;
  end

  // Datapath, counter, HI/LO and the registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= {CNT_W{1'b0}};
      op_div    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_zero  <= 1'b0;
      operand   <= {WIDTH{1'b0}};
      orig_val1 <= {WIDTH{1'b0}};
      acc_hi    <= {WIDTH{1'b0}};
      acc_lo    <= {WIDTH{1'b0}};
      hi        <= {WIDTH{1'b0}};
      lo        <= {WIDTH{1'b0}};
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= finish;

      if (accept || bus.flush) begin
        cnt <= {CNT_W{1'b0}};
      end else if (iterate) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (accept) begin
        op_div    <= (bus.inst_func == FUNCT_DIV) || (bus.inst_func == FUNCT_DIVU);
        neg_q     <= sign1 ^ sign2;
        neg_r     <= sign1;
        div_zero  <= (bus.val2_in == {WIDTH{1'b0}});
        orig_val1 <= bus.val1_in;
        acc_hi    <= {WIDTH{1'b0}};
        if ((bus.inst_func == FUNCT_DIV) || (bus.inst_func == FUNCT_DIVU)) begin
          operand <= abs2;
          acc_lo  <= abs1;
        end else begin
          operand <= abs1;
          acc_lo  <= abs2;
        end
      end else if (iterate) begin
        if (op_div) begin
          // restoring step: keep the difference only when it did not borrow
          acc_hi <= add_cout ? add_sum[WIDTH-1:0] : add_a[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], add_cout};
        end else begin
          // shift-add step: sum (with carry) drops into the top, LSB into acc_lo
          acc_hi <= add_sum[WIDTH:1];
          acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
        end
      end

      if (finish) begin
        if (!op_div) begin
          hi <= prod_fix[2*WIDTH-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
        end else if (div_zero) begin
          hi <= orig_val1;
          lo <= {WIDTH{1'b1}};
        end else begin
          hi <= rem_fix;
          lo <= quo_fix;
        end
      end else begin
        if (mt_hi) begin
          hi <= bus.val1_in;
        end
        if (mt_lo) begin
          lo <= bus.val1_in;
        end
      end
    end
  end

  assign bus.busy      = busy;
  assign bus.stall_req = busy;
  assign bus.done      = done;
  assign bus.hi        = hi;
  assign bus.lo        = lo;

endmodule

// File: tb/tb_exe_muldiv.sv
// Self-checking bench for exe_muldiv: directed cases plus randomized mul/div
// traffic compared against an arithmetic reference of HI/LO.
module tb_exe_muldiv;
  import cpu_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   passed;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  exe_muldiv_if #(.WIDTH(32)) bus ();

  exe_muldiv #(.WIDTH(32), .ITERS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference HI/LO from plain integer arithmetic.
  task automatic ref_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] p;
    logic signed [63:0] q;
    logic signed [63:0] r;
    case (f)
      FUNCT_MULT: begin
        p = 64'(longint'($signed(a)) * longint'($signed(b)));
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      FUNCT_MULTU: begin
        p = {32'h0, a} * {32'h0, b};
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      FUNCT_DIV: begin
        if (b == 32'h0) begin
          m_hi = a; m_lo = 32'hFFFF_FFFF;
        end else begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          m_hi = r[31:0]; m_lo = q[31:0];
        end
      end
      FUNCT_DIVU: begin
        if (b == 32'h0) begin
          m_hi = a; m_lo = 32'hFFFF_FFFF;
        end else begin
          m_hi = a % b; m_lo = a / b;
        end
      end
      default: begin
        m_hi = m_hi; m_lo = m_lo;
      end
    endcase
  endtask

  // Issue one mul/div at the next edge and follow it to completion.
  task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int cyc;
    @(negedge clk);
    bus.start = 1'b1; bus.inst_func = f; bus.val1_in = a; bus.val2_in = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    ref_md(f, a, b);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      if (bus.stall_req !== 1'b1) cyc = cyc + 100;
      cyc++;
    end
    check({tag, " busy_cycles"}, 64'(cyc), 64'd33);
    check({tag, " done"}, {63'd0, bus.done}, 64'd1);
    check({tag, " hi"}, {32'd0, bus.hi}, {32'd0, m_hi});
    check({tag, " lo"}, {32'd0, bus.lo}, {32'd0, m_lo});
    @(negedge clk);
    check({tag, " done_pulse"}, {63'd0, bus.done}, 64'd0);
  endtask

  task automatic run_mt(input string tag, input logic [5:0] f, input logic [31:0] a);
    @(negedge clk);
    bus.start = 1'b1; bus.inst_func = f; bus.val1_in = a;
    @(posedge clk);
    #1 bus.start = 1'b0;
    if (f == FUNCT_MTHI) m_hi = a; else m_lo = a;
    @(negedge clk);
    check({tag, " hi"}, {32'd0, bus.hi}, {32'd0, m_hi});
    check({tag, " lo"}, {32'd0, bus.lo}, {32'd0, m_lo});
    check({tag, " busy"}, {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    int seen_done;
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  md_funcs [4];
    md_funcs = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
    total = 0; passed = 0;
    m_hi = 32'h0; m_lo = 32'h0;
    rst = 1'b1;
    bus.start = 1'b0; bus.inst_func = 6'h00; bus.val1_in = 32'h0;
    bus.val2_in = 32'h0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset busy", {63'd0, bus.busy}, 64'd0);
    check("reset stall", {63'd0, bus.stall_req}, 64'd0);
    check("reset done", {63'd0, bus.done}, 64'd0);
    check("reset hi", {32'd0, bus.hi}, 64'd0);
    check("reset lo", {32'd0, bus.lo}, 64'd0);

    // Directed cases with hand-derived results.
    run_md("mult_7_m3", FUNCT_MULT, 32'd7, 32'hFFFF_FFFD);
    check("mult_7_m3 const hi", {32'd0, bus.hi}, 64'hFFFF_FFFF);
    check("mult_7_m3 const lo", {32'd0, bus.lo}, 64'hFFFF_FFEB);
    run_md("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    run_md("div_m7_2", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_m7_2 const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_md("divu_100_7", FUNCT_DIVU, 32'd100, 32'd7);
    check("divu_100_7 const", {bus.hi, bus.lo}, {32'd2, 32'd14});
    run_md("divu_by0", FUNCT_DIVU, 32'h64, 32'h0);
    check("divu_by0 const", {bus.hi, bus.lo}, 64'h0000_0064_FFFF_FFFF);
    run_md("div_by0", FUNCT_DIV, 32'hFFFF_FF00, 32'h0);
    run_md("div_ovf", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf const", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);

    // MTHI then a MULT squashed by flush on RUN cycle 10.
    run_mt("mthi", FUNCT_MTHI, 32'h1234);
    @(negedge clk);
    bus.start = 1'b1; bus.inst_func = FUNCT_MULT; bus.val1_in = 32'd3; bus.val2_in = 32'd4;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    check("flush busy", {63'd0, bus.busy}, 64'd0);
    check("flush hi", {32'd0, bus.hi}, {32'd0, m_hi});
    check("flush lo", {32'd0, bus.lo}, {32'd0, m_lo});
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done || bus.busy) seen_done++;
      @(negedge clk);
    end
    check("flush no_done", 64'(seen_done), 64'd0);
    check("flush hi later", {32'd0, bus.hi}, 64'h1234);

    // Flush together with MTLO in IDLE: nothing is written.
    @(negedge clk);
    bus.start = 1'b1; bus.inst_func = FUNCT_MTLO; bus.val1_in = 32'hDEAD_BEEF; bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    check("flush_mtlo lo", {32'd0, bus.lo}, {32'd0, m_lo});

    // Reset in the middle of RUN.
    @(negedge clk);
    bus.start = 1'b1; bus.inst_func = FUNCT_DIVU; bus.val1_in = 32'd1000; bus.val2_in = 32'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_hi = 32'h0; m_lo = 32'h0;
    @(negedge clk);
    check("midrst busy", {63'd0, bus.busy}, 64'd0);
    check("midrst hilo", {bus.hi, bus.lo}, 64'd0);
    run_md("mult_5_6", FUNCT_MULT, 32'd5, 32'd6);
    check("mult_5_6 const", {bus.hi, bus.lo}, 64'd30);

    // Randomized traffic, with small and zero divisors mixed in.
    for (int n = 0; n < 24; n++) begin
      f = md_funcs[$urandom_range(0, 3)];
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'h0;
        1:       b = 32'($urandom_range(1, 20));
        2:       b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      if (n % 6 == 5) run_mt("rand_mtlo", FUNCT_MTLO, a);
      run_md("rand", f, a, b);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
